// File: rtl/spi_frame_controller.sv
// SPI mode-0 initiator: serialises FRAME_BITS-wide frames MSB-first on sclk/copi/ncs.
// Define SPI_FRAME_CONTROLLER_READBACK_EN to add cipo capture into rx_data.
module spi_frame_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  copi,
  output logic                  ncs
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
  ,
  input  logic                  cipo,
  output logic [FRAME_BITS-1:0] rx_data
`endif
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = $clog2(FRAME_BITS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sclk_d, copi_d, ncs_d, done_d;
  logic                  div_end;

`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_d;
`endif

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign div_end  = (div_q == DIV_LAST);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      ncs     <= 1'b1;
      done    <= 1'b0;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
      rx_shift_q <= '0;
      rx_data    <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk    <= sclk_d;
      copi    <= copi_d;
      ncs     <= ncs_d;
      done    <= done_d;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
      rx_shift_q <= rx_shift_d;
      rx_data    <= rx_data_d;
`endif
    end
  end

  // Next-state and next-output logic; every non-IDLE state lasts CLK_DIV cycles
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk;
    copi_d  = copi;
    ncs_d   = ncs;
    done_d  = 1'b0;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data;
`endif

    if (state_q != IDLE) begin
      div_d = div_end ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          bit_d   = '0;
          div_d   = '0;
          ncs_d   = 1'b0;
          copi_d  = tx_data[FRAME_BITS-1];
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_end) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], cipo};
`endif
        end
      end
      HIGH: begin
        if (div_end) begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q << 1;
            copi_d  = shift_q[FRAME_BITS-2];
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (div_end) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], cipo};
`endif
        end
      end
      HOLD: begin
        if (div_end) begin
          ncs_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SPI_FRAME_CONTROLLER_READBACK_EN
          rx_data_d = rx_shift_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
